// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory write arbiter.
// Field widths follow the codebase's memory command/status streams.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } arb_state_t;

    localparam int ADDR_W = 64;
    localparam int LEN_W  = 32;
    localparam int STS_W  = 8;
    localparam int USER_W = 1;

    // Requester index width; a single requester still needs one bit.
    function automatic int tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Small in-order FIFO of requester tags awaiting status.
// Head is read combinationally so status steering adds no latency.
module arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin sharing of one memory write channel (command, data, status)
// among NUM_REQ requesters; a grant lasts until the command's stream ends.
module mem_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                                  aclk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    s_cmd_valid_i,
    output logic [NUM_REQ-1:0]                    s_cmd_ready_o,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]        s_cmd_addr_i,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]         s_cmd_len_i,
    input  logic [NUM_REQ-1:0]                    s_data_valid_i,
    output logic [NUM_REQ-1:0]                    s_data_ready_o,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    s_data_data_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  s_data_keep_i,
    input  logic [NUM_REQ-1:0]                    s_data_last_i,
    input  logic [NUM_REQ-1:0][USER_W-1:0]        s_data_user_i,
    output logic [NUM_REQ-1:0]                    s_sts_valid_o,
    input  logic [NUM_REQ-1:0]                    s_sts_ready_i,
    output logic [NUM_REQ-1:0][STS_W-1:0]         s_sts_data_o,
    output logic                                  m_cmd_valid_o,
    input  logic                                  m_cmd_ready_i,
    output logic [ADDR_W-1:0]                     m_cmd_addr_o,
    output logic [LEN_W-1:0]                      m_cmd_len_o,
    output logic                                  m_data_valid_o,
    input  logic                                  m_data_ready_i,
    output logic [DATA_WIDTH-1:0]                 m_data_data_o,
    output logic [DATA_WIDTH/8-1:0]               m_data_keep_o,
    output logic                                  m_data_last_o,
    output logic [USER_W-1:0]                     m_data_user_o,
    input  logic                                  m_sts_valid_i,
    output logic                                  m_sts_ready_o,
    input  logic [STS_W-1:0]                      m_sts_data_i
);

    localparam int TAG_W = tag_width(NUM_REQ);

    arb_state_t        state_q, state_d;
    logic [TAG_W-1:0]  grant_q, grant_d;
    logic [TAG_W-1:0]  rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;

    logic [TAG_W:0]    pick;
    logic [TAG_W-1:0]  pick_idx;
    logic              tag_push;
    logic              tag_pop;
    logic [TAG_W-1:0]  tag_head;
    logic              tag_empty;
    logic              tag_full;

    // Returns {found, index} of the first requester after 'last', wrapping.
    function automatic logic [TAG_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [TAG_W-1:0]   last);
        logic [TAG_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx]) begin
                res = {1'b1, TAG_W'(idx)};
            end
        end
        return res;
    endfunction

    assign pick_idx = pick[TAG_W-1:0];

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_last_d      = rr_last_q;
        cmd_addr_d     = cmd_addr_q;
        cmd_len_d      = cmd_len_q;
        s_cmd_ready_o  = '0;
        s_data_ready_o = '0;
        m_cmd_valid_o  = 1'b0;
        m_data_valid_o = 1'b0;
        m_data_last_o  = 1'b0;
        tag_push       = 1'b0;
        pick           = rr_pick(s_cmd_valid_i, rr_last_q);

        case (state_q)
            IDLE: begin
                // Reset gating keeps ready low while reset is held.
                if (pick[TAG_W] && !tag_full && !reset) begin
                    grant_d                 = pick_idx;
                    cmd_addr_d              = s_cmd_addr_i[pick_idx];
                    cmd_len_d               = s_cmd_len_i[pick_idx];
                    s_cmd_ready_o[pick_idx] = 1'b1;
                    state_d                 = CMD;
                end
            end
            CMD: begin
                m_cmd_valid_o = 1'b1;
                if (m_cmd_ready_i) begin
                    tag_push = 1'b1;
                    if (cmd_len_q == '0) begin
                        rr_last_d = grant_q;
                        state_d   = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                m_data_valid_o          = s_data_valid_i[grant_q];
                m_data_last_o           = s_data_last_i[grant_q];
                s_data_ready_o[grant_q] = m_data_ready_i;
                if (s_data_valid_i[grant_q] && m_data_ready_i && s_data_last_i[grant_q]) begin
                    rr_last_d = grant_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_cmd_addr_o  = cmd_addr_q;
    assign m_cmd_len_o   = cmd_len_q;
    assign m_data_data_o = s_data_data_i[grant_q];
    assign m_data_keep_o = s_data_keep_i[grant_q];
    assign m_data_user_o = s_data_user_i[grant_q];

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_last_q  <= TAG_W'(NUM_REQ - 1);
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_len_q  <= cmd_len_d;
        end
    end

    // Status returns in command order, so the FIFO head names its owner.
    assign m_sts_ready_o = !tag_empty && s_sts_ready_i[tag_head];
    assign tag_pop       = m_sts_valid_i && m_sts_ready_o;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sts
        assign s_sts_valid_o[gi] = m_sts_valid_i && !tag_empty && (tag_head == TAG_W'(gi));
        assign s_sts_data_o[gi]  = m_sts_data_i;
    end

    arb_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (aclk),
        .srst      (reset),
        .push      (tag_push),
        .push_data (grant_q),
        .pop       (tag_pop),
        .head      (tag_head),
        .empty     (tag_empty),
        .full      (tag_full)
    );

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter: vector table plus corner-case
// sequences, with scoreboard queues for commands, beats and statuses.
module tb_mem_write_arbiter;
    import mem_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int TD = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]             s_cmd_valid;
    logic [NR-1:0]             s_cmd_ready;
    logic [NR-1:0][ADDR_W-1:0] s_cmd_addr;
    logic [NR-1:0][LEN_W-1:0]  s_cmd_len;
    logic [NR-1:0]             s_data_valid;
    logic [NR-1:0]             s_data_ready;
    logic [NR-1:0][DW-1:0]     s_data_data;
    logic [NR-1:0][KW-1:0]     s_data_keep;
    logic [NR-1:0]             s_data_last;
    logic [NR-1:0][USER_W-1:0] s_data_user;
    logic [NR-1:0]             s_sts_valid;
    logic [NR-1:0]             s_sts_ready;
    logic [NR-1:0][STS_W-1:0]  s_sts_data;
    logic                      m_cmd_valid;
    logic                      m_cmd_ready;
    logic [ADDR_W-1:0]         m_cmd_addr;
    logic [LEN_W-1:0]          m_cmd_len;
    logic                      m_data_valid;
    logic                      m_data_ready = 1'b1;
    logic [DW-1:0]             m_data_data;
    logic [KW-1:0]             m_data_keep;
    logic                      m_data_last;
    logic [USER_W-1:0]         m_data_user;
    logic                      m_sts_valid;
    logic                      m_sts_ready;
    logic [STS_W-1:0]          m_sts_data;

    mem_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .aclk(clk), .reset(reset),
        .s_cmd_valid_i(s_cmd_valid), .s_cmd_ready_o(s_cmd_ready),
        .s_cmd_addr_i(s_cmd_addr), .s_cmd_len_i(s_cmd_len),
        .s_data_valid_i(s_data_valid), .s_data_ready_o(s_data_ready),
        .s_data_data_i(s_data_data), .s_data_keep_i(s_data_keep),
        .s_data_last_i(s_data_last), .s_data_user_i(s_data_user),
        .s_sts_valid_o(s_sts_valid), .s_sts_ready_i(s_sts_ready), .s_sts_data_o(s_sts_data),
        .m_cmd_valid_o(m_cmd_valid), .m_cmd_ready_i(m_cmd_ready),
        .m_cmd_addr_o(m_cmd_addr), .m_cmd_len_o(m_cmd_len),
        .m_data_valid_o(m_data_valid), .m_data_ready_i(m_data_ready),
        .m_data_data_o(m_data_data), .m_data_keep_o(m_data_keep),
        .m_data_last_o(m_data_last), .m_data_user_o(m_data_user),
        .m_sts_valid_i(m_sts_valid), .m_sts_ready_o(m_sts_ready), .m_sts_data_i(m_sts_data)
    );

    typedef struct {
        int          req;
        logic [63:0] addr;
        logic [31:0] len;
    } cmd_exp_t;

    typedef struct {
        int            req;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_exp_t;

    typedef struct {
        int          req;
        logic [63:0] addr;
        logic [31:0] len;
        int          beats;
        int          stall;
        logic [7:0]  sts;
    } vec_t;

    cmd_exp_t  cmd_q[$];
    beat_exp_t beat_q[$];
    int        sts_q[$];

    int  errors = 0;
    int  checks = 0;
    bit  in_stream = 1'b0;
    int  stream_req = 0;
    bit  toggle_en = 1'b0;
    int  seq = 0;

    int        mon_h;
    logic      mon_er;
    cmd_exp_t  mon_c;
    beat_exp_t mon_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got nothing expected event", name);
    endtask

    function automatic logic [NR-1:0] onehot(input int r);
        logic [NR-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (toggle_en) m_data_ready = ~m_data_ready;
        else           m_data_ready = 1'b1;
    end

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (m_sts_valid) begin
            if (sts_q.size() == 0) begin
                chk("sts_idle_valid", 64'(s_sts_valid), 64'd0);
                chk("sts_idle_ready", 64'(m_sts_ready), 64'd0);
            end else begin
                mon_h  = sts_q[0];
                mon_er = s_sts_ready[mon_h];
                chk("sts_route", 64'(s_sts_valid), 64'(onehot(mon_h)));
                chk("sts_ready", 64'(m_sts_ready), 64'(mon_er));
                chk("sts_data", 64'(s_sts_data[mon_h]), 64'(m_sts_data));
                if (mon_er) void'(sts_q.pop_front());
            end
        end
        if (m_cmd_valid && m_cmd_ready) begin
            if (cmd_q.size() == 0) fail_now("unexpected_cmd");
            else begin
                mon_c = cmd_q.pop_front();
                $display("cmd  req=%0d addr=%0h len=%0d", mon_c.req, m_cmd_addr, m_cmd_len);
                chk("cmd_addr", m_cmd_addr, mon_c.addr);
                chk("cmd_len", 64'(m_cmd_len), 64'(mon_c.len));
                sts_q.push_back(mon_c.req);
            end
        end
        if (m_data_valid && m_data_ready) begin
            if (beat_q.size() == 0) fail_now("unexpected_beat");
            else begin
                mon_b = beat_q.pop_front();
                $display("beat req=%0d data=%0h last=%0b", mon_b.req, m_data_data, m_data_last);
                chk("beat_data", 64'(m_data_data), 64'(mon_b.data));
                chk("beat_keep", 64'(m_data_keep), 64'(mon_b.keep));
                chk("beat_last", 64'(m_data_last), 64'(mon_b.last));
                chk("beat_user", 64'(m_data_user), 64'(mon_b.user));
                chk("beat_ready_route", 64'(s_data_ready), 64'(onehot(mon_b.req)));
            end
        end
        if (in_stream) begin
            chk("no_regrant", 64'(s_cmd_ready), 64'd0);
            chk("others_blocked", 64'(s_data_ready & ~onehot(stream_req)), 64'd0);
        end
    end

    task automatic check_reset_outputs();
        @(negedge clk);
        chk("rst_m_cmd_valid", 64'(m_cmd_valid), 64'd0);
        chk("rst_m_cmd_addr", m_cmd_addr, 64'd0);
        chk("rst_m_cmd_len", 64'(m_cmd_len), 64'd0);
        chk("rst_m_data_valid", 64'(m_data_valid), 64'd0);
        chk("rst_m_data_last", 64'(m_data_last), 64'd0);
        chk("rst_s_cmd_ready", 64'(s_cmd_ready), 64'd0);
        chk("rst_s_data_ready", 64'(s_data_ready), 64'd0);
        chk("rst_s_sts_valid", 64'(s_sts_valid), 64'd0);
        chk("rst_m_sts_ready", 64'(m_sts_ready), 64'd0);
    endtask

    task automatic issue_cmd(input int r, input logic [63:0] addr, input logic [31:0] len);
        s_cmd_valid[r] = 1'b1;
        s_cmd_addr[r]  = addr;
        s_cmd_len[r]   = len;
        cmd_q.push_back('{req: r, addr: addr, len: len});
    endtask

    task automatic accept_cmd(input int r, input int stall, input logic [63:0] addr);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_cmd_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("grant_timeout");
        else chk("grant_onehot", 64'(s_cmd_ready), 64'(onehot(r)));
        @(posedge clk);
        #1;
        s_cmd_valid[r] = 1'b0;
        if (stall > 0) begin
            m_cmd_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("m_cmd_hold_valid", 64'(m_cmd_valid), 64'd1);
                chk("m_cmd_hold_addr", m_cmd_addr, addr);
                @(posedge clk);
                #1;
            end
            m_cmd_ready = 1'b1;
        end
    endtask

    task automatic send_beats(input int r, input int first, input int count, input int total);
        bit ok;
        seq++;
        for (int b = first; b < first + count; b++) begin
            s_data_valid[r] = 1'b1;
            s_data_data[r]  = {8'(r), 8'(seq), 16'(b)};
            s_data_keep[r]  = KW'(r + b + 1);
            s_data_last[r]  = (b == total - 1);
            s_data_user[r]  = USER_W'(b & 1);
            beat_q.push_back('{req: r, data: {8'(r), 8'(seq), 16'(b)}, keep: KW'(r + b + 1),
                               last: (b == total - 1), user: 1'(b & 1)});
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (s_data_ready[r]) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                fail_now("beat_timeout");
                break;
            end
            @(posedge clk);
            #1;
        end
        s_data_valid[r] = 1'b0;
        s_data_last[r]  = 1'b0;
    endtask

    task automatic send_status(input logic [7:0] data, input bit pre_stall);
        bit ok;
        m_sts_data  = data;
        m_sts_valid = 1'b1;
        if (pre_stall) begin
            s_sts_ready = '0;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            s_sts_ready = '1;
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_sts_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("status_timeout");
        else $display("sts  data=%0h to=%b", data, s_sts_valid);
        @(posedge clk);
        #1;
        m_sts_valid = 1'b0;
    endtask

    task automatic drain_status();
        int k;
        k = 0;
        while (sts_q.size() > 0 && k < 40) begin
            send_status(8'(k * 17 + 3), k == 1);
            k++;
        end
    endtask

    vec_t vecs[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int g;
        vecs[0] = '{req: 1, addr: 64'h1000, len: 32'd128, beats: 2, stall: 0, sts: 8'h00};
        vecs[1] = '{req: 2, addr: 64'hDEAD_BEEF_0000_0040, len: 32'd64, beats: 1, stall: 2, sts: 8'h81};
        vecs[2] = '{req: 0, addr: 64'h20, len: 32'd256, beats: 4, stall: 1, sts: 8'h7E};
        vecs[3] = '{req: 3, addr: 64'hFFFF_FFFF_FFFF_FFC0, len: 32'hFFFF_FFFF, beats: 3, stall: 0, sts: 8'hFF};

        s_cmd_valid = '0; s_cmd_addr = '0; s_cmd_len = '0;
        s_data_valid = '0; s_data_data = '0; s_data_keep = '0; s_data_last = '0; s_data_user = '0;
        s_sts_ready = '1; m_cmd_ready = 1'b1; m_sts_valid = 1'b0; m_sts_data = '0;

        // Reset state with live requests and status present.
        reset = 1'b1;
        s_cmd_valid[2] = 1'b1;
        m_sts_valid = 1'b1;
        m_sts_data = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_cmd_valid = '0;
        m_sts_valid = 1'b0;

        // Round robin, all requesters valid, 1-beat streams.
        for (int r = 0; r < NR; r++) begin
            s_cmd_addr[r] = 64'h100 * 64'(r + 1);
            s_cmd_len[r]  = 32'd64;
        end
        s_cmd_valid = '1;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            g = -1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (|s_cmd_ready) begin
                    ok = 1'b1;
                    for (int r = 0; r < NR; r++) if (s_cmd_ready[r]) g = r;
                    break;
                end
            end
            if (!ok) begin
                fail_now("rr_timeout");
                break;
            end
            chk("rr_grant", 64'(s_cmd_ready), 64'(onehot(k % NR)));
            cmd_q.push_back('{req: k % NR, addr: 64'h100 * 64'((k % NR) + 1), len: 32'd64});
            @(posedge clk);
            #1;
            if (k == 4) s_cmd_valid = '0;
            send_beats(k % NR, 0, 1, 1);
        end
        drain_status();

        // Table of single-requester transactions.
        for (int i = 0; i < 4; i++) begin
            issue_cmd(vecs[i].req, vecs[i].addr, vecs[i].len);
            accept_cmd(vecs[i].req, vecs[i].stall, vecs[i].addr);
            send_beats(vecs[i].req, 0, vecs[i].beats, vecs[i].beats);
            send_status(vecs[i].sts, i == 2);
        end

        // Requester 2, 8 beats under 50% backpressure; requester 0 waits.
        issue_cmd(2, 64'h8000, 32'd256);
        accept_cmd(2, 0, 64'h8000);
        toggle_en = 1'b1;
        stream_req = 2;
        in_stream = 1'b1;
        issue_cmd(0, 64'h9000, 32'd0);
        send_beats(2, 0, 8, 8);
        in_stream = 1'b0;
        toggle_en = 1'b0;
        accept_cmd(0, 0, 64'h9000);
        drain_status();

        // Zero-length from requester 3 must still advance the round robin.
        issue_cmd(1, 64'hA000, 32'd64);
        accept_cmd(1, 0, 64'hA000);
        send_beats(1, 0, 1, 1);
        issue_cmd(3, 64'hB000, 32'd0);
        accept_cmd(3, 0, 64'hB000);
        s_data_valid[3] = 1'b1;
        s_data_last[3]  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("zero_len_no_data", 64'(m_data_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        s_data_valid[3] = 1'b0;
        s_data_last[3]  = 1'b0;
        issue_cmd(0, 64'hC000, 32'd0);
        issue_cmd(2, 64'hD000, 32'd0);
        accept_cmd(0, 0, 64'hC000);
        accept_cmd(2, 0, 64'hD000);
        drain_status();

        // Fill the tag FIFO; the 17th command waits for one status.
        for (int i = 0; i < TD; i++) begin
            issue_cmd(i % NR, 64'h10000 + 64'(i * 64), 32'd0);
            accept_cmd(i % NR, 0, 64'h10000 + 64'(i * 64));
        end
        issue_cmd(0, 64'hF000, 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("full_stall", 64'(s_cmd_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        send_status(8'hC3, 1'b0);
        accept_cmd(0, 0, 64'hF000);
        drain_status();

        // Reset in the middle of a stream.
        issue_cmd(1, 64'hCAFE_0000, 32'd64);
        accept_cmd(1, 0, 64'hCAFE_0000);
        send_beats(1, 0, 2, 4);
        reset = 1'b1;
        cmd_q.delete();
        beat_q.delete();
        sts_q.delete();
        @(posedge clk);
        #1;
        s_cmd_valid[2]  = 1'b1;
        s_data_valid[1] = 1'b1;
        s_data_last[1]  = 1'b1;
        m_sts_valid     = 1'b1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_data_valid[1] = 1'b0;
        s_data_last[1]  = 1'b0;
        m_sts_valid     = 1'b0;
        issue_cmd(0, 64'hE000, 32'd0);
        issue_cmd(2, 64'hE100, 32'd0);
        accept_cmd(0, 0, 64'hE000);
        accept_cmd(2, 0, 64'hE100);
        drain_status();

        repeat (3) @(posedge clk);
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        chk("beat_q_drained", 64'(beat_q.size()), 64'd0);
        chk("sts_q_drained", 64'(sts_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
